// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stepper_pkg
// Description : Shared definitions for the unipolar stepper controller:
//               drive-mode encodings, FSM state type and the 8-entry
//               coil phase table.
// Revision    : 1.0 - initial release
// ============================================================================
package stepper_pkg;

  localparam logic [1:0] MODE_WAVE = 2'b00;
  localparam logic [1:0] MODE_FULL = 2'b01;
  localparam logic [1:0] MODE_HALF = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Even indices energise one coil, odd indices energise two adjacent coils.
  function automatic logic [3:0] phase_pattern(input logic [2:0] p);
    logic [3:0] pat;
    case (p)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stepper_motor_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : stepper_motor_ctrl_if
// Description : Command/status bundle between motion-command logic (master)
//               and the stepper controller (slave).
//   start/dir/mode/steps/div : move command, sampled when accepted
//   abort                    : terminate current move
//   hold                     : keep coils energised while idle
//   busy/done                : move status, done is a one-cycle pulse
//   coil                     : registered coil drive pattern
//   position                 : signed step position (STEPPER_POS_EN only)
// Configuration: STEPPER_POS_EN adds the position signal and POS_W.
// Revision    : 1.0 - initial release
// ============================================================================
interface stepper_motor_ctrl_if #(
  parameter int STEP_CNT_W = 16,
  parameter int DIV_W      = 16
`ifdef STEPPER_POS_EN
  , parameter int POS_W    = 32
`endif
);

  logic                  start;
  logic                  dir;
  logic [1:0]            mode;
  logic [STEP_CNT_W-1:0] steps;
  logic [DIV_W-1:0]      div;
  logic                  abort;
  logic                  hold;
  logic                  busy;
  logic                  done;
  logic [3:0]            coil;
`ifdef STEPPER_POS_EN
  logic signed [POS_W-1:0] position;
`endif

  modport master (
    output start, dir, mode, steps, div, abort, hold,
    input  busy, done, coil
`ifdef STEPPER_POS_EN
    , input position
`endif
  );

  modport slave (
    input  start, dir, mode, steps, div, abort, hold,
    output busy, done, coil
`ifdef STEPPER_POS_EN
    , output position
`endif
  );

endinterface
`default_nettype wire

// File: rtl/stepper_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : stepper_tick_gen
// Description : Step-rate prescaler. Counts 0..div while enabled and asserts
//               tick for one cycle when the count equals div, then wraps.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear of the count (takes priority over en)
//   en       : count enable
//   div      : terminal count (period minus one)
//   tick     : one-cycle step strobe
// Revision    : 1.0 - initial release
// ============================================================================
module stepper_tick_gen #(
  parameter int DIV_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr,
  input  wire logic             en,
  input  wire logic [DIV_W-1:0] div,
  output logic                  tick
);

  logic [DIV_W-1:0] r_cnt;

  assign tick = en && (r_cnt == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stepper_motor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stepper_motor_ctrl
// Description : Counted, rate-controlled 4-phase unipolar stepper controller
//               with wave, full-step and half-step drive.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : stepper_motor_ctrl_if.slave (command, status, coil, position)
// Configuration: define STEPPER_POS_EN to add the signed position counter.
// Revision    : 1.0 - initial release
// ============================================================================
module stepper_motor_ctrl
  import stepper_pkg::*;
#(
  parameter int STEP_CNT_W = 16,
  parameter int DIV_W      = 16
`ifdef STEPPER_POS_EN
  , parameter int POS_W    = 32
`endif
) (
  input  wire logic           clk,
  input  wire logic           rst,
  stepper_motor_ctrl_if.slave bus
);

  state_t                r_state;
  logic [2:0]            r_p;
  logic                  r_dir;
  logic                  r_half;
  logic [STEP_CNT_W-1:0] r_remaining;
  logic [DIV_W-1:0]      r_div;
  logic                  r_done;
  logic [3:0]            r_coil;

  logic       w_accept;
  logic       w_tick;
  logic       w_step;
  logic       w_last;
  logic       w_busy_next;
  logic [2:0] w_p_aligned;
  logic [2:0] w_delta;
  logic [2:0] w_p_stepped;
  logic [2:0] w_p_next;

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  // Abort overrides a coincident tick, so no step is taken on that edge.
  assign w_step   = (r_state == ST_RUN) && !bus.abort && w_tick;
  assign w_last   = w_step && (r_remaining == {{(STEP_CNT_W-1){1'b0}}, 1'b1});

  stepper_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_accept),
    .en   (r_state == ST_RUN),
    .div  (r_div),
    .tick (w_tick)
  );

  // Wave uses even table entries, full uses odd ones; half keeps p as is.
  always_comb begin
    w_p_aligned = r_p;
    case (bus.mode)
      MODE_WAVE: w_p_aligned = {r_p[2:1], 1'b0};
      MODE_HALF: w_p_aligned = r_p;
      default:   w_p_aligned = {r_p[2:1], 1'b1};
    endcase
  end

  assign w_delta     = r_half ? 3'd1 : 3'd2;
  assign w_p_stepped = r_dir ? (r_p - w_delta) : (r_p + w_delta);
  assign w_p_next    = w_accept ? w_p_aligned : (w_step ? w_p_stepped : r_p);

  // Coil is registered, so it is derived from the post-edge busy and phase.
  assign w_busy_next = (r_state == ST_RUN) ? !(bus.abort || w_last)
                                           : (w_accept && (bus.steps != '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_p         <= 3'd0;
      r_dir       <= 1'b0;
      r_half      <= 1'b0;
      r_remaining <= '0;
      r_div       <= '0;
      r_done      <= 1'b0;
      r_coil      <= 4'b0000;
    end else begin
      r_done <= 1'b0;
      r_p    <= w_p_next;
      r_coil <= (w_busy_next || bus.hold) ? phase_pattern(w_p_next) : 4'b0000;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_dir       <= bus.dir;
            r_half      <= (bus.mode == MODE_HALF);
            r_remaining <= bus.steps;
            r_div       <= bus.div;
            if (bus.steps == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_remaining <= r_remaining - 1'b1;
            if (w_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = r_done;
  assign bus.coil = r_coil;

`ifdef STEPPER_POS_EN
  logic signed [POS_W-1:0] r_pos;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos <= '0;
    end else if (w_step) begin
      r_pos <= r_dir ? (r_pos - 1'b1) : (r_pos + 1'b1);
    end
  end

  assign bus.position = r_pos;
`endif

endmodule
`default_nettype wire
